bubble_boot_sequencer: RTL and testbench
========================================

# bubble_boot_sequencer

Power-up and image-load sequencer for the bubble memory emulator. It debounces the host `power_good`, latches the DIP-selected image number, and runs a request/ack/done handshake with the SPI flash loader, retrying failed loads. After a warm-up delay it raises the READY (`temperature_low`) signal to the BUBBLE SYSTEM board and enables the bubble interface. It sits between the board-level inputs, the SPI loader and the bubble interface.

## Interface
- `STABLE_CYCLES`, 511: consecutive synced `power_good`-high cycles required before latching the image.
- `WARMUP_CYCLES`, 1023: cycles spent in WARMUP before READY is raised.
- `LOAD_TIMEOUT`, 65535: maximum cycles from ack to done or error; when exceeded, the load is treated as an error.
- `MAX_RETRY`, 2: number of load retries after the first failure.
- `CNT_WIDTH`, 24: shared down/up counter width; must hold the largest of the three cycle parameters.
- `master_clock` in 1: 48 MHz master clock.
- `reset` in 1: asynchronous, active-high reset.
- `power_good` in 1: asynchronous input from the board; synchronized internally with 2 flops.
- `image_dip_switch` in 3: active-low image select; static while sampled.
- `loader_req` out 1: load request to the SPI loader.
- `loader_ack` in 1: loader accepted the request (level, held ≥1 cycle).
- `loader_done` in 1: one-cycle pulse, load completed OK.
- `loader_error` in 1: one-cycle pulse, load failed.
- `image_number` out 3: selected image, valid from LATCH onward.
- `temperature_low` out 1: READY to the host, high only in RUN.
- `bubble_module_enable` out 1: active low, low only in RUN.
- `fault` out 1: high only in FAULT.
- `seq_state` out 3: current state encoding (debug).

## Operation
- States and encodings: OFF=0, STABLE=1, LATCH=2, LOAD_REQ=3, LOAD_WAIT=4, WARMUP=5, RUN=6, FAULT=7.
- OFF: counter=0 and retry count=0. Go to STABLE when `pg_s` (the synced `power_good`) is 1.
- STABLE: counter increments while `pg_s`=1. When the counter reaches STABLE_CYCLES−1, go to LATCH.
- LATCH: `image_number` ← ~`image_dip_switch`. Stay exactly 1 cycle, then go to LOAD_REQ.
- LOAD_REQ: `loader_req`=1. When `loader_ack`=1 is sampled, go to LOAD_WAIT and clear the counter.
- LOAD_WAIT: `loader_req`=0. The counter increments each cycle.
  - `loader_done` → WARMUP with the counter cleared.
  - `loader_error`, or the counter reaching LOAD_TIMEOUT−1, counts as a failure.
    - If retry count < MAX_RETRY: increment it and go to LOAD_REQ.
    - Otherwise: go to FAULT.
  - `loader_done` and `loader_error` in the same cycle: the error wins.
- WARMUP: the counter increments. When it reaches WARMUP_CYCLES−1, go to RUN.
- RUN: `temperature_low`=1 and `bubble_module_enable`=0. Stay until `pg_s`=0.
- FAULT: `fault`=1. Only `pg_s`=0 or `reset` exits.
- `pg_s`=0 in any state: go to OFF next cycle. This has priority over all other transitions.
  - `loader_req` drops immediately.
  - `image_number` holds its last value until the next LATCH.
- Outputs are registered and derived from the state register; no combinational path from inputs to outputs.
- Counter arithmetic: unsigned CNT_WIDTH bits, saturating, with no wrap. Comparisons use equality with the parameter minus 1.

## Timing
- Reset values:
  - state=OFF, counter=0, retry count=0
  - `loader_req`=0, `image_number`=3'b000
  - `temperature_low`=0, `bubble_module_enable`=1, `fault`=0, `seq_state`=0
- `power_good` rise to first STABLE cycle: 3 cycles (2 sync flops plus the state register).
- `power_good` rise to `temperature_low`=1, error-free load, ack in the first REQ cycle and done D cycles after ack: 3 + STABLE_CYCLES + 1 + 1 + D + WARMUP_CYCLES cycles.
- `power_good` fall to `temperature_low`=0 and `bubble_module_enable`=1: 3 cycles.
- `loader_req` rises the cycle after LATCH. It falls the cycle after `loader_ack` is sampled high.
- Reset asserted mid-sequence: all outputs return to their reset values asynchronously. After release, the sequence restarts from OFF.

## Test plan
- Clean boot with STABLE=511, WARMUP=1023, DIP=3'b101, ack after 2 cycles, done 10 cycles later → `image_number`=3'b010, then `temperature_low`=1 and `bubble_module_enable`=0 exactly at the latency above.
- `power_good` glitch high for 100 cycles, then low → returns to OFF, `loader_req` never asserted, `image_number` stays 3'b000.
- `loader_error` on the first two attempts and done on the third → `loader_req` pulses 3 times, RUN is reached, `fault`=0.
- Three consecutive errors with MAX_RETRY=2 → `fault`=1, `seq_state`=7, `temperature_low`=0; `power_good` low then high → sequence restarts and `fault`=0.
- `loader_done` and `loader_error` in the same cycle → counted as a retry. No ack after the request and no done within LOAD_TIMEOUT after ack → counted as a failure.
- `power_good` drops during WARMUP, and separately `reset` is pulsed during LOAD_WAIT → OFF within 3 cycles and reset values asynchronously, respectively; a full re-boot afterwards succeeds.

Source files
------------

// File: rtl/bubble_boot_sequencer.sv
// Power-up / image-load sequencer: debounces power_good, latches the DIP image,
// drives the SPI loader handshake with retries, then warms up and raises READY.
module bubble_boot_sequencer #(
  parameter int unsigned STABLE_CYCLES = 511,
  parameter int unsigned WARMUP_CYCLES = 1023,
  parameter int unsigned LOAD_TIMEOUT  = 65535,
  parameter int unsigned MAX_RETRY     = 2,
  parameter int unsigned CNT_WIDTH     = 24
) (
  input  logic       master_clock,
  input  logic       reset,
  input  logic       power_good,
  input  logic [2:0] image_dip_switch,
  output logic       loader_req,
  input  logic       loader_ack,
  input  logic       loader_done,
  input  logic       loader_error,
  output logic [2:0] image_number,
  output logic       temperature_low,
  output logic       bubble_module_enable,
  output logic       fault,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_STABLE    = 3'd1,
    S_LATCH     = 3'd2,
    S_LOAD_REQ  = 3'd3,
    S_LOAD_WAIT = 3'd4,
    S_WARMUP    = 3'd5,
    S_RUN       = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WARMUP_LAST = CNT_WIDTH'(WARMUP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LOAD_LAST   = CNT_WIDTH'(LOAD_TIMEOUT - 1);
  localparam logic [RW-1:0]        RETRY_MAX   = RW'(MAX_RETRY);

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic [RW-1:0]        r_retry;
  logic [RW-1:0]        w_retry_next;
  logic                 w_fail;

  logic       r_pg_meta;
  logic       r_pg_s;
  logic [2:0] r_image;
  logic       r_req;
  logic       r_temp;
  logic       r_bme;
  logic       r_fault;
  logic [2:0] r_seq;

  always_comb begin
    w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + CNT_WIDTH'(1);
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_retry_next = r_retry;
    w_fail       = 1'b0;

    if (!r_pg_s) begin
      w_state_next = S_OFF;
      w_cnt_next   = '0;
      w_retry_next = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_cnt_next   = '0;
          w_retry_next = '0;
          w_state_next = S_STABLE;
        end
        S_STABLE: begin
          if (r_cnt == STABLE_LAST) begin
            w_state_next = S_LATCH;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
        S_LATCH: begin
          w_cnt_next   = '0;
          w_state_next = S_LOAD_REQ;
        end
        S_LOAD_REQ: begin
          w_cnt_next = '0;
          if (loader_ack) w_state_next = S_LOAD_WAIT;
        end
        S_LOAD_WAIT: begin
          w_cnt_next = w_cnt_inc;
          // error beats done; a done arriving on the timeout cycle still counts as success
          if (loader_error) begin
            w_fail = 1'b1;
          end else if (loader_done) begin
            w_state_next = S_WARMUP;
            w_cnt_next   = '0;
          end else if (r_cnt == LOAD_LAST) begin
            w_fail = 1'b1;
          end
          if (w_fail) begin
            w_cnt_next = '0;
            if (r_retry < RETRY_MAX) begin
              w_retry_next = r_retry + RW'(1);
              w_state_next = S_LOAD_REQ;
            end else begin
              w_state_next = S_FAULT;
            end
          end
        end
        S_WARMUP: begin
          if (r_cnt == WARMUP_LAST) begin
            w_state_next = S_RUN;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
        S_RUN:   w_cnt_next = '0;
        S_FAULT: w_cnt_next = '0;
        default: w_state_next = S_OFF;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge master_clock or posedge reset) begin
    if (reset) begin
      r_pg_meta <= 1'b0;
      r_pg_s    <= 1'b0;
      r_state   <= S_OFF;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_image   <= '0;
      r_req     <= 1'b0;
      r_temp    <= 1'b0;
      r_bme     <= 1'b1;
      r_fault   <= 1'b0;
      r_seq     <= '0;
    end else begin
      r_pg_meta <= power_good;
      r_pg_s    <= r_pg_meta;
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_retry   <= w_retry_next;
      if (w_state_next == S_LATCH) r_image <= ~image_dip_switch;
      r_req     <= (w_state_next == S_LOAD_REQ);
      r_temp    <= (w_state_next == S_RUN);
      r_bme     <= (w_state_next != S_RUN);
      r_fault   <= (w_state_next == S_FAULT);
      r_seq     <= w_state_next;
    end
  end

  assign loader_req           = r_req;
  assign image_number         = r_image;
  assign temperature_low      = r_temp;
  assign bubble_module_enable = r_bme;
  assign fault                = r_fault;
  assign seq_state            = r_seq;

endmodule

// File: tb/tb_bubble_boot_sequencer.sv
// Directed bench for bubble_boot_sequencer: boot latency, glitch rejection,
// retries, fault, timeout, power drop and asynchronous reset.
module tb_bubble_boot_sequencer;

  localparam int unsigned STB = 511;
  localparam int unsigned WRM = 1023;
  localparam int unsigned LTO = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic       power_good;
  logic [2:0] image_dip_switch;
  logic       loader_req;
  logic       loader_ack;
  logic       loader_done;
  logic       loader_error;
  logic [2:0] image_number;
  logic       temperature_low;
  logic       bubble_module_enable;
  logic       fault;
  logic [2:0] seq_state;

  int vec  = 0;
  int errs = 0;
  int req_rises = 0;
  int rises0;

  bubble_boot_sequencer #(
    .STABLE_CYCLES(STB),
    .WARMUP_CYCLES(WRM),
    .LOAD_TIMEOUT (LTO),
    .MAX_RETRY    (2),
    .CNT_WIDTH    (24)
  ) dut (
    .master_clock        (clk),
    .reset               (reset),
    .power_good          (power_good),
    .image_dip_switch    (image_dip_switch),
    .loader_req          (loader_req),
    .loader_ack          (loader_ack),
    .loader_done         (loader_done),
    .loader_error        (loader_error),
    .image_number        (image_number),
    .temperature_low     (temperature_low),
    .bubble_module_enable(bubble_module_enable),
    .fault               (fault),
    .seq_state           (seq_state)
  );

  always #5 clk = ~clk;

  always @(posedge loader_req) req_rises++;

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Drives power_good high from OFF and lands in the first LOAD_REQ cycle.
  task automatic power_on(input logic [2:0] dip);
    image_dip_switch = dip;
    power_good = 1'b1;
    tick(STB + 4);
  endtask

  task automatic power_off;
    power_good = 1'b0;
    tick(3);
  endtask

  task automatic ack_now;
    loader_ack = 1'b1;
    tick(1);
    loader_ack = 1'b0;
  endtask

  task automatic pulse_done;
    loader_done = 1'b1;
    tick(1);
    loader_done = 1'b0;
  endtask

  task automatic pulse_err;
    loader_error = 1'b1;
    tick(1);
    loader_error = 1'b0;
  endtask

  task automatic test_reset;
    vec++; if (seq_state !== 3'd0) begin errs++; $display("FAIL rst_seq: got %0d exp 0", seq_state); end
    vec++; if (loader_req !== 1'b0) begin errs++; $display("FAIL rst_req: got %b exp 0", loader_req); end
    vec++; if (image_number !== 3'b000) begin errs++; $display("FAIL rst_img: got %b exp 000", image_number); end
    vec++; if (temperature_low !== 1'b0) begin errs++; $display("FAIL rst_temp: got %b exp 0", temperature_low); end
    vec++; if (bubble_module_enable !== 1'b1) begin errs++; $display("FAIL rst_bme: got %b exp 1", bubble_module_enable); end
    vec++; if (fault !== 1'b0) begin errs++; $display("FAIL rst_fault: got %b exp 0", fault); end
    reset = 1'b0;
    tick(5);
    vec++; if (seq_state !== 3'd0) begin errs++; $display("FAIL off_hold_seq: got %0d exp 0", seq_state); end
  endtask

  task automatic test_glitch;
    rises0 = req_rises;
    image_dip_switch = 3'b010;
    power_good = 1'b1;
    tick(100);
    vec++; if (seq_state !== 3'd1) begin errs++; $display("FAIL glitch_stable: got %0d exp 1", seq_state); end
    power_good = 1'b0;
    tick(2);
    vec++; if (seq_state !== 3'd1) begin errs++; $display("FAIL glitch_lag: got %0d exp 1", seq_state); end
    tick(1);
    vec++; if (seq_state !== 3'd0) begin errs++; $display("FAIL glitch_off: got %0d exp 0", seq_state); end
    vec++; if (req_rises !== rises0) begin errs++; $display("FAIL glitch_req: got %0d rises exp 0", req_rises - rises0); end
    vec++; if (image_number !== 3'b000) begin errs++; $display("FAIL glitch_img: got %b exp 000", image_number); end
  endtask

  task automatic test_clean_boot;
    image_dip_switch = 3'b101;
    power_good = 1'b1;
    tick(2);
    vec++; if (seq_state !== 3'd0) begin errs++; $display("FAIL boot_sync2: got %0d exp 0", seq_state); end
    tick(1);
    vec++; if (seq_state !== 3'd1) begin errs++; $display("FAIL boot_sync3: got %0d exp 1", seq_state); end
    tick(STB - 1);
    vec++; if (seq_state !== 3'd1) begin errs++; $display("FAIL boot_stable_end: got %0d exp 1", seq_state); end
    tick(1);
    vec++; if (seq_state !== 3'd2) begin errs++; $display("FAIL boot_latch: got %0d exp 2", seq_state); end
    vec++; if (image_number !== 3'b010) begin errs++; $display("FAIL boot_img: got %b exp 010", image_number); end
    vec++; if (loader_req !== 1'b0) begin errs++; $display("FAIL boot_req_latch: got %b exp 0", loader_req); end
    tick(1);
    vec++; if (loader_req !== 1'b1) begin errs++; $display("FAIL boot_req_rise: got %b exp 1", loader_req); end
    tick(2);
    vec++; if (loader_req !== 1'b1) begin errs++; $display("FAIL boot_req_hold: got %b exp 1", loader_req); end
    loader_ack = 1'b1;
    tick(1);
    loader_ack = 1'b0;
    vec++; if (loader_req !== 1'b0) begin errs++; $display("FAIL boot_req_fall: got %b exp 0", loader_req); end
    vec++; if (seq_state !== 3'd4) begin errs++; $display("FAIL boot_wait: got %0d exp 4", seq_state); end
    tick(9);
    pulse_done;
    vec++; if (seq_state !== 3'd5) begin errs++; $display("FAIL boot_warmup: got %0d exp 5", seq_state); end
    tick(WRM - 1);
    vec++; if (temperature_low !== 1'b0) begin errs++; $display("FAIL boot_temp_early: got %b exp 0", temperature_low); end
    tick(1);
    vec++; if (temperature_low !== 1'b1) begin errs++; $display("FAIL boot_temp: got %b exp 1", temperature_low); end
    vec++; if (bubble_module_enable !== 1'b0) begin errs++; $display("FAIL boot_bme: got %b exp 0", bubble_module_enable); end
    vec++; if (seq_state !== 3'd6) begin errs++; $display("FAIL boot_run: got %0d exp 6", seq_state); end
    power_good = 1'b0;
    tick(2);
    vec++; if (temperature_low !== 1'b1) begin errs++; $display("FAIL down_temp_lag: got %b exp 1", temperature_low); end
    tick(1);
    vec++; if (temperature_low !== 1'b0) begin errs++; $display("FAIL down_temp: got %b exp 0", temperature_low); end
    vec++; if (bubble_module_enable !== 1'b1) begin errs++; $display("FAIL down_bme: got %b exp 1", bubble_module_enable); end
    vec++; if (image_number !== 3'b010) begin errs++; $display("FAIL down_img_hold: got %b exp 010", image_number); end
  endtask

  task automatic test_retry;
    rises0 = req_rises;
    power_on(3'b000);
    vec++; if (image_number !== 3'b111) begin errs++; $display("FAIL retry_img: got %b exp 111", image_number); end
    ack_now;
    tick(2);
    pulse_err;
    vec++; if (loader_req !== 1'b1) begin errs++; $display("FAIL retry1_req: got %b exp 1", loader_req); end
    ack_now;
    pulse_err;
    vec++; if (seq_state !== 3'd3) begin errs++; $display("FAIL retry2_seq: got %0d exp 3", seq_state); end
    ack_now;
    pulse_done;
    tick(WRM);
    vec++; if (temperature_low !== 1'b1) begin errs++; $display("FAIL retry_run: got %b exp 1", temperature_low); end
    vec++; if (fault !== 1'b0) begin errs++; $display("FAIL retry_fault: got %b exp 0", fault); end
    vec++; if (req_rises - rises0 !== 3) begin errs++; $display("FAIL retry_pulses: got %0d exp 3", req_rises - rises0); end
    power_off;
  endtask

  task automatic test_fault;
    power_on(3'b110);
    ack_now; pulse_err;
    ack_now; pulse_err;
    ack_now; pulse_err;
    vec++; if (seq_state !== 3'd7) begin errs++; $display("FAIL fault_seq: got %0d exp 7", seq_state); end
    vec++; if (fault !== 1'b1) begin errs++; $display("FAIL fault_flag: got %b exp 1", fault); end
    vec++; if (temperature_low !== 1'b0) begin errs++; $display("FAIL fault_temp: got %b exp 0", temperature_low); end
    tick(20);
    vec++; if (seq_state !== 3'd7) begin errs++; $display("FAIL fault_sticky: got %0d exp 7", seq_state); end
    power_off;
    vec++; if (fault !== 1'b0) begin errs++; $display("FAIL fault_clear: got %b exp 0", fault); end
    power_on(3'b110);
    vec++; if (seq_state !== 3'd3) begin errs++; $display("FAIL fault_restart: got %0d exp 3", seq_state); end
    ack_now; pulse_err;
    vec++; if (seq_state !== 3'd3) begin errs++; $display("FAIL fault_retry_cleared: got %0d exp 3", seq_state); end
    power_off;
  endtask

  task automatic test_done_err_timeout;
    power_on(3'b001);
    ack_now;
    loader_done = 1'b1;
    loader_error = 1'b1;
    tick(1);
    loader_done = 1'b0;
    loader_error = 1'b0;
    vec++; if (seq_state !== 3'd3) begin errs++; $display("FAIL both_retry: got %0d exp 3", seq_state); end
    ack_now;
    tick(LTO - 1);
    vec++; if (seq_state !== 3'd4) begin errs++; $display("FAIL tmo_early: got %0d exp 4", seq_state); end
    tick(1);
    vec++; if (loader_req !== 1'b1) begin errs++; $display("FAIL tmo_retry: got %b exp 1", loader_req); end
    ack_now; pulse_err;
    vec++; if (seq_state !== 3'd7) begin errs++; $display("FAIL tmo_fault: got %0d exp 7", seq_state); end
    power_off;
  endtask

  task automatic test_drop_and_reset;
    power_on(3'b100);
    ack_now; pulse_done;
    tick(100);
    power_good = 1'b0;
    tick(2);
    vec++; if (seq_state !== 3'd5) begin errs++; $display("FAIL drop_lag: got %0d exp 5", seq_state); end
    tick(1);
    vec++; if (seq_state !== 3'd0) begin errs++; $display("FAIL drop_off: got %0d exp 0", seq_state); end
    power_on(3'b011);
    ack_now;
    tick(5);
    vec++; if (image_number !== 3'b100) begin errs++; $display("FAIL pre_rst_img: got %b exp 100", image_number); end
    reset = 1'b1;
    #1;
    vec++; if (seq_state !== 3'd0) begin errs++; $display("FAIL arst_seq: got %0d exp 0", seq_state); end
    vec++; if (image_number !== 3'b000) begin errs++; $display("FAIL arst_img: got %b exp 000", image_number); end
    vec++; if (bubble_module_enable !== 1'b1) begin errs++; $display("FAIL arst_bme: got %b exp 1", bubble_module_enable); end
    tick(2);
    reset = 1'b0;
    power_on(3'b011);
    vec++; if (loader_req !== 1'b1) begin errs++; $display("FAIL reboot_req: got %b exp 1", loader_req); end
    vec++; if (image_number !== 3'b100) begin errs++; $display("FAIL reboot_img: got %b exp 100", image_number); end
    ack_now; pulse_done;
    tick(WRM);
    vec++; if (temperature_low !== 1'b1) begin errs++; $display("FAIL reboot_temp: got %b exp 1", temperature_low); end
    vec++; if (bubble_module_enable !== 1'b0) begin errs++; $display("FAIL reboot_bme: got %b exp 0", bubble_module_enable); end
  endtask

  initial begin
    reset = 1'b1;
    power_good = 1'b0;
    image_dip_switch = 3'b111;
    loader_ack = 1'b0;
    loader_done = 1'b0;
    loader_error = 1'b0;
    tick(3);
    test_reset;
    test_glitch;
    test_clean_boot;
    test_retry;
    test_fault;
    test_done_err_timeout;
    test_drop_and_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
